// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI mode 0 responder, oversampled in the i_clk domain.
// Full-duplex bytes, MSB first, with a one-entry TX holding buffer and a
// one-entry RX output register, both behind valid/ready handshakes.
// Optional feature macro: SPI_SLAVE_ERR_FLAGS_EN (sticky overrun/underrun
// flags). With it undefined the flags are tied low and i_err_clr is unused.
module spi_slave_port #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TX_FILL     = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_spi_sclk,
  input  logic       i_spi_mosi,
  input  logic       i_spi_ss_n,
  output logic       o_spi_miso,
  output logic       o_spi_miso_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_busy,
  output logic       o_rx_overrun,
  output logic       o_tx_underrun,
  input  logic       i_err_clr
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  // Edges after reset until both the synced ss_n and its delayed copy hold
  // real pin samples rather than reset values.
  localparam int SETTLE_MAX = SYNC_STAGES + 1;
  localparam int SW         = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ssn_sync_q;
  logic                   sclk_prev_q, ssn_prev_q;
  logic [SW-1:0]          settle_q;

  logic sclk_s, mosi_s, ssn_s;
  logic sclk_rise, sclk_fall, ss_fall, settled;

  // Synchronizer chains, sclk/ss_n delay flops and the post-reset settle counter.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the synchronizer chain.
    if (!i_reset_n) begin
      // NOTE: ss_n resets to "deselected" so o_busy reads 0 during reset and
      // the pad state cannot look like a select until the chain is refilled.
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ssn_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ssn_prev_q  <= 1'b1;
      settle_q    <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
      ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], i_spi_ss_n};
      sclk_prev_q <= sclk_s;
      ssn_prev_q  <= ssn_s;
      if (!settled) settle_q <= settle_q + 1'b1;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ssn_s     = ssn_sync_q[SYNC_STAGES-1];
  assign settled   = (settle_q == SW'(SETTLE_MAX));
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // A select held low through reset is not a fresh fall: only accept a
  // high-to-low seen on real samples.
  assign ss_fall   = settled & ssn_prev_q & ~ssn_s;

  logic       state_q,    state_d;
  logic [2:0] bit_cnt_q,  bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] txbuf_q,    txbuf_d;
  logic       txfull_q,   txfull_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       miso_q,     miso_d;
  logic       oe_q,       oe_d;
  logic       ovr_evt, und_evt, load_shift, byte_done;
  logic       tx_accept, rx_accept;

  assign tx_accept = i_tx_valid & ~txfull_q;
  assign rx_accept = i_rx_ready & rx_valid_q;

  // Frame FSM, RX/TX shifters and both handshake buffers.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    txbuf_d    = txbuf_q;
    txfull_d   = txfull_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovr_evt    = 1'b0;
    und_evt    = 1'b0;
    load_shift = 1'b0;
    byte_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 3'd0;
        if (ss_fall) begin
          state_d    = ST_ACTIVE;
          load_shift = 1'b1;
        end
      end
      default: begin
        if (ssn_s) begin
          // Deselect: drop any partial byte; the holding buffer is kept.
          state_d    = ST_IDLE;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 8'd0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            byte_done  = (bit_cnt_q == 3'd7);
          end
          if (sclk_fall) begin
            if (bit_cnt_q != 3'd0) begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end else begin
              load_shift = 1'b1;
              und_evt    = ~txfull_q;
            end
          end
        end
      end
    endcase

    // Shifter load takes the old buffer content before any new byte lands.
    if (load_shift) begin
      tx_shift_d = txfull_q ? txbuf_q : TX_FILL;
      if (txfull_q) txfull_d = 1'b0;
    end
    if (tx_accept) begin
      txbuf_d  = i_tx_data;
      txfull_d = 1'b1;
    end

    if (rx_accept) rx_valid_d = 1'b0;
    if (byte_done) begin
      if (!rx_valid_q || rx_accept) begin
        rx_data_d  = {rx_shift_q[6:0], mosi_s};
        rx_valid_d = 1'b1;
      end else begin
        ovr_evt = 1'b1;
      end
    end

    oe_d   = (state_d == ST_ACTIVE);
    miso_d = oe_d ? tx_shift_d[7] : 1'b0;
  end

  // Register the FSM, data path and MISO pad outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'd0;
      tx_shift_q <= 8'd0;
      txbuf_q    <= 8'd0;
      txfull_q   <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      txbuf_q    <= txbuf_d;
      txfull_q   <= txfull_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
    end
  end

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic ovr_flag_q, und_flag_q;

  // Sticky error flags; a clear in the same cycle as an event wins.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ovr_flag_q <= 1'b0;
      und_flag_q <= 1'b0;
    end else if (i_err_clr) begin
      ovr_flag_q <= 1'b0;
      und_flag_q <= 1'b0;
    end else begin
      ovr_flag_q <= ovr_flag_q | ovr_evt;
      und_flag_q <= und_flag_q | und_evt;
    end
  end

  assign o_rx_overrun  = ovr_flag_q;
  assign o_tx_underrun = und_flag_q;
`else
  logic unused_err;
  assign unused_err    = ^{i_err_clr, ovr_evt, und_evt};
  assign o_rx_overrun  = 1'b0;
  assign o_tx_underrun = 1'b0;
`endif

  assign o_spi_miso    = miso_q;
  assign o_spi_miso_oe = oe_q;
  assign o_tx_ready    = ~txfull_q;
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_busy        = ~ssn_s;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed testbench for spi_slave_port: an SPI mode 0 master with a
// half-period of 4 i_clk cycles, plus fabric-side TX/RX handshakes.
// Flag expectations follow SPI_SLAVE_ERR_FLAGS_EN.
module tb_spi_slave_port;

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  localparam logic [7:0] FLAG_EXP = 8'd1;
`else
  localparam logic [7:0] FLAG_EXP = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sclk, mosi, ss_n;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       busy, rx_overrun, tx_underrun, err_clr;

  int checks = 0;
  int errors = 0;

  spi_slave_port #(.SYNC_STAGES(2), .TX_FILL(8'hFF)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_spi_sclk   (sclk),
    .i_spi_mosi   (mosi),
    .i_spi_ss_n   (ss_n),
    .o_spi_miso   (miso),
    .o_spi_miso_oe(miso_oe),
    .i_tx_data    (tx_data),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .i_rx_ready   (rx_ready),
    .o_busy       (busy),
    .o_rx_overrun (rx_overrun),
    .o_tx_underrun(tx_underrun),
    .i_err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one byte to the TX holding buffer; it must be ready.
  task automatic tx_push(input logic [7:0] b);
    @(negedge clk);
    check("tx_ready_before_push", 8'(tx_ready), 8'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_after_push", 8'(tx_ready), 8'd0);
  endtask

  // Check the pending RX byte, accept it, and confirm valid drops.
  task automatic rx_pop(input string tag, input logic [7:0] b);
    check({tag, "_valid"}, 8'(rx_valid), 8'd1);
    check({tag, "_data"}, rx_data, b);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    check({tag, "_cleared"}, 8'(rx_valid), 8'd0);
  endtask

  // Master clocks n bits of b MSB first, sampling MISO just before each rise.
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] got);
    got = 8'd0;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      wait_clks(4);
      got  = {got[6:0], miso};
      sclk = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    ss_n = 1'b0;
    wait_clks(4);
  endtask

  task automatic frame_end();
    wait_clks(4);
    ss_n = 1'b1;
    wait_clks(6);
  endtask

  task automatic clear_flags();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  logic [7:0] got;

  initial begin
    reset_n  = 1'b0;
    sclk     = 1'b0;
    mosi     = 1'b0;
    ss_n     = 1'b0;
    tx_data  = 8'd0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    err_clr  = 1'b0;

    // Reset held with the bus active and sclk toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sclk = ~sclk;
      mosi = ~mosi;
    end
    @(negedge clk);
    sclk = 1'b0;
    check("rst_miso", 8'(miso), 8'd0);
    check("rst_miso_oe", 8'(miso_oe), 8'd0);
    check("rst_tx_ready", 8'(tx_ready), 8'd1);
    check("rst_rx_data", rx_data, 8'd0);
    check("rst_rx_valid", 8'(rx_valid), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_overrun", 8'(rx_overrun), 8'd0);
    check("rst_underrun", 8'(tx_underrun), 8'd0);

    // Release with ss_n still low: no fresh fall, so the block stays idle.
    reset_n = 1'b1;
    mosi    = 1'b0;
    wait_clks(10);
    check("held_ss_busy", 8'(busy), 8'd1);
    check("held_ss_idle_oe", 8'(miso_oe), 8'd0);
    ss_n = 1'b1;
    wait_clks(6);
    check("deselect_busy", 8'(busy), 8'd0);

    // Full duplex: slave sends A5 while master sends 3C.
    tx_push(8'hA5);
    frame_start();
    check("fd_oe_active", 8'(miso_oe), 8'd1);
    check("fd_ready_after_load", 8'(tx_ready), 8'd1);
    spi_bits(8'h3C, 8, got);
    check("fd_miso_byte", got, 8'hA5);
    frame_end();
    check("fd_oe_idle", 8'(miso_oe), 8'd0);
    wait_clks(10);
    rx_pop("fd_rx", 8'h3C);

    // Back-to-back bytes in one frame; second TX byte loaded mid-frame.
    tx_push(8'h12);
    frame_start();
    tx_push(8'h34);
    spi_bits(8'h01, 8, got);
    check("b2b_miso0", got, 8'h12);
    rx_pop("b2b_rx0", 8'h01);
    spi_bits(8'h02, 8, got);
    check("b2b_miso1", got, 8'h34);
    rx_pop("b2b_rx1", 8'h02);
    frame_end();

    // Underrun and overrun: nothing buffered, consumer stalled.
    clear_flags();
    check("pre_overrun_clear", 8'(rx_overrun), 8'd0);
    check("pre_underrun_clear", 8'(tx_underrun), 8'd0);
    frame_start();
    spi_bits(8'h55, 8, got);
    check("ur_miso0", got, 8'hFF);
    check("ur_rx_valid0", 8'(rx_valid), 8'd1);
    spi_bits(8'hAA, 8, got);
    check("ur_miso1", got, 8'hFF);
    frame_end();
    check("ovr_rx_kept", rx_data, 8'h55);
    check("ovr_rx_valid", 8'(rx_valid), 8'd1);
    check("ovr_flag", 8'(rx_overrun), FLAG_EXP);
    check("ur_flag", 8'(tx_underrun), FLAG_EXP);
    clear_flags();
    check("clr_overrun", 8'(rx_overrun), 8'd0);
    check("clr_underrun", 8'(tx_underrun), 8'd0);
    rx_pop("ovr_rx", 8'h55);

    // Abort after 5 bits: partial RX dropped, loaded TX byte consumed.
    tx_push(8'hC3);
    frame_start();
    spi_bits(8'h00, 5, got);
    check("abort_miso_bits", got, 8'h18);
    frame_end();
    check("abort_no_rx", 8'(rx_valid), 8'd0);
    check("abort_tx_ready", 8'(tx_ready), 8'd1);
    frame_start();
    spi_bits(8'h81, 8, got);
    check("post_abort_miso", got, 8'hFF);
    frame_end();
    rx_pop("post_abort_rx", 8'h81);

    // Reset mid-transfer with a byte sitting in the holding buffer.
    frame_start();
    tx_push(8'h77);
    spi_bits(8'hF0, 3, got);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_oe", 8'(miso_oe), 8'd0);
    check("midrst_tx_ready", 8'(tx_ready), 8'd1);
    check("midrst_rx_valid", 8'(rx_valid), 8'd0);
    check("midrst_miso", 8'(miso), 8'd0);
    reset_n = 1'b1;
    wait_clks(10);
    check("midrst_stays_idle", 8'(miso_oe), 8'd0);
    ss_n = 1'b1;
    wait_clks(6);

    // Fresh frame after the reset still works.
    frame_start();
    spi_bits(8'h5A, 8, got);
    check("after_rst_miso", got, 8'hFF);
    frame_end();
    rx_pop("after_rst_rx", 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
